// File: rtl/alu_issue_pkg.sv
// Shared opcode constants, FSM state encoding and ALU control payload for the ALU issue controller.
package alu_issue_pkg;

    localparam int unsigned OP_WIDTH    = 4;
    localparam int unsigned COUNT_WIDTH = 16;

    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_LSH = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_RSH = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_AND = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_INV = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_CLR = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic add;
        logic sub;
        logic lsr;
        logic lsh;
        logic rsh;
        logic band;
        logic bor;
        logic bxor;
        logic inv;
        logic clr;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_issue_controller_decode.sv
// Combinational opcode decode: one-hot ALU control for the execute cycle, shift and illegal flags.
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    output alu_ctrl_t           ctrl_c,
    output logic                is_shift_c,
    output logic                illegal_c
);

    always_comb begin
        ctrl_c     = '0;
        is_shift_c = 1'b0;
        illegal_c  = 1'b0;
        case (op)
            OP_ADD:  ctrl_c.add  = 1'b1;
            OP_SUB:  ctrl_c.sub  = 1'b1;
            OP_LSH: begin
                ctrl_c.lsh = 1'b1;
                is_shift_c = 1'b1;
            end
            OP_RSH: begin
                ctrl_c.rsh = 1'b1;
                is_shift_c = 1'b1;
            end
            OP_AND:  ctrl_c.band = 1'b1;
            OP_OR:   ctrl_c.bor  = 1'b1;
            OP_XOR:  ctrl_c.bxor = 1'b1;
            OP_INV:  ctrl_c.inv  = 1'b1;
            OP_CLR:  ctrl_c.clr  = 1'b1;
            default: illegal_c   = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_controller.sv
// Issues one request at a time to an external ALU and returns its result with a flag/err response.
// Optional ALU_ISSUE_OPCOUNT_EN adds a saturating 16-bit count of response handshakes (op_count).
module alu_issue_controller
    import alu_issue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic                  alu_add,
    output logic                  alu_sub,
    output logic                  alu_lsr,
    output logic                  alu_lsh,
    output logic                  alu_rsh,
    output logic                  alu_and,
    output logic                  alu_or,
    output logic                  alu_xor,
    output logic                  alu_inv,
    output logic                  alu_clr,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_overflow,
    input  logic                  alu_shift_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_flag,
    output logic                  rsp_err
`ifdef ALU_ISSUE_OPCOUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] op_count
`endif
);

    state_e                state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    alu_ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_flag_q, rsp_flag_d;
    logic                  rsp_err_q, rsp_err_d;

    logic      accept;
    alu_ctrl_t dec_ctrl;
    logic      dec_shift;
    logic      dec_illegal;

    // Request capture; decode always sees the op the FSM is about to work on.
    always_comb begin
        accept = req_valid && (state_q == ST_IDLE);
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        if (accept) begin
            op_d = req_op;
            a_d  = req_a;
            b_d  = req_b;
        end
    end

    alu_op_decode u_decode (
        .op         (op_d),
        .ctrl_c     (dec_ctrl),
        .is_shift_c (dec_shift),
        .illegal_c  (dec_illegal)
    );

    // Next state plus registered outputs derived from the upcoming state.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_flag_d = rsp_flag_q;
        rsp_err_d  = rsp_err_q;
        ctrl_d     = '0;
        in1_d      = '0;
        in2_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_data_d = '0;
                    rsp_flag_d = 1'b0;
                    rsp_err_d  = dec_illegal;
                    if (dec_illegal) begin
                        state_d = ST_RESP;
                    end else if (dec_shift) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: begin
                rsp_data_d = alu_out;
                rsp_err_d  = 1'b0;
                if (dec_ctrl.add || dec_ctrl.sub) begin
                    rsp_flag_d = alu_overflow;
                end else if (dec_shift) begin
                    rsp_flag_d = alu_shift_flag;
                end else begin
                    rsp_flag_d = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_LOAD) begin
            ctrl_d.lsr = 1'b1;
        end else if (state_d == ST_EXEC) begin
            ctrl_d = dec_ctrl;
        end
        if ((state_d == ST_LOAD) || (state_d == ST_EXEC)) begin
            in1_d = a_d;
            in2_d = b_d;
        end
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flag_q  <= rsp_flag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef ALU_ISSUE_OPCOUNT_EN
    logic [COUNT_WIDTH-1:0] op_count_q, op_count_d;

    // Saturating count of completed response handshakes.
    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid_q && rsp_ready && (op_count_q != '1)) begin
            op_count_d = op_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flag  = rsp_flag_q;
    assign rsp_err   = rsp_err_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_add   = ctrl_q.add;
    assign alu_sub   = ctrl_q.sub;
    assign alu_lsr   = ctrl_q.lsr;
    assign alu_lsh   = ctrl_q.lsh;
    assign alu_rsh   = ctrl_q.rsh;
    assign alu_and   = ctrl_q.band;
    assign alu_or    = ctrl_q.bor;
    assign alu_xor   = ctrl_q.bxor;
    assign alu_inv   = ctrl_q.inv;
    assign alu_clr   = ctrl_q.clr;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Self-checking bench for alu_issue_controller: behavioural ALU, directed scenarios and randomized traffic.
module tb_alu_issue_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a, req_b;
    logic [7:0] alu_in1, alu_in2;
    logic       alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
    logic       alu_and, alu_or, alu_xor, alu_inv, alu_clr;
    logic [7:0] alu_out;
    logic       alu_overflow, alu_shift_flag;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_flag, rsp_err;
`ifdef ALU_ISSUE_OPCOUNT_EN
    logic [15:0] op_count;
    int unsigned exp_count = 0;
`endif

    int checks = 0;
    int errors = 0;

    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    logic       ovr_flag = 1'b0;

    logic [9:0] ctl;
    assign ctl = {alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh,
                  alu_and, alu_or, alu_xor, alu_inv, alu_clr};

    always #5 clk = ~clk;

    alu_issue_controller #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_add        (alu_add),
        .alu_sub        (alu_sub),
        .alu_lsr        (alu_lsr),
        .alu_lsh        (alu_lsh),
        .alu_rsh        (alu_rsh),
        .alu_and        (alu_and),
        .alu_or         (alu_or),
        .alu_xor        (alu_xor),
        .alu_inv        (alu_inv),
        .alu_clr        (alu_clr),
        .alu_out        (alu_out),
        .alu_overflow   (alu_overflow),
        .alu_shift_flag (alu_shift_flag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_flag       (rsp_flag),
        .rsp_err        (rsp_err)
`ifdef ALU_ISSUE_OPCOUNT_EN
        ,
        .op_count       (op_count)
`endif
    );

    // Control line expected during the execute cycle of each legal opcode.
    function automatic logic [9:0] opmask(input logic [3:0] op);
        case (op)
            4'd0:    return 10'b1000000000;
            4'd1:    return 10'b0100000000;
            4'd2:    return 10'b0001000000;
            4'd3:    return 10'b0000100000;
            4'd4:    return 10'b0000010000;
            4'd5:    return 10'b0000001000;
            4'd6:    return 10'b0000000100;
            4'd7:    return 10'b0000000010;
            4'd8:    return 10'b0000000001;
            default: return 10'b0000000000;
        endcase
    endfunction

    // Reference ALU: {flag, result}; flag is carry/borrow for add/sub, shifted-out bit for shifts.
    function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        case (op)
            4'd0:    t = {1'b0, a} + {1'b0, b};
            4'd1:    t = {1'b0, a} - {1'b0, b};
            4'd2:    t = {a[7], a[6:0], 1'b0};
            4'd3:    t = {a[0], 1'b0, a[7:1]};
            4'd4:    t = {1'b0, a & b};
            4'd5:    t = {1'b0, a | b};
            4'd6:    t = {1'b0, a ^ b};
            4'd7:    t = {1'b0, ~a};
            default: t = 9'h000;
        endcase
        return t;
    endfunction

    // Bench-side ALU; the flag not relevant to the active op is driven opposite to expose wrong selection.
    always_comb begin
        logic [8:0] r;
        logic [3:0] aop;
        logic       known;
        alu_out        = 8'hA5;
        alu_overflow   = 1'b1;
        alu_shift_flag = 1'b1;
        known          = 1'b1;
        aop            = 4'd0;
        r              = 9'h000;
        case (ctl)
            10'b1000000000: aop = 4'd0;
            10'b0100000000: aop = 4'd1;
            10'b0001000000: aop = 4'd2;
            10'b0000100000: aop = 4'd3;
            10'b0000010000: aop = 4'd4;
            10'b0000001000: aop = 4'd5;
            10'b0000000100: aop = 4'd6;
            10'b0000000010: aop = 4'd7;
            10'b0000000001: aop = 4'd8;
            default:        known = 1'b0;
        endcase
        if (known) begin
            r       = ref_alu(aop, alu_in1, alu_in2);
            alu_out = r[7:0];
            if (aop <= 4'd1) begin
                alu_overflow   = r[8];
                alu_shift_flag = ~r[8];
            end else if (aop <= 4'd3) begin
                alu_shift_flag = r[8];
                alu_overflow   = ~r[8];
            end
        end
        if (ovr_en && (ctl != 10'b0)) begin
            alu_out        = ovr_val;
            alu_shift_flag = ovr_flag;
            alu_overflow   = ~ovr_flag;
        end
    end

    // One request through accept, per-cycle ALU controls, response with backpressure, handshake.
    task automatic do_txn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [8:0] r;
        logic [7:0] ed;
        logic       ef, ee;
        logic [9:0] ec;
        int         lat;
        r   = ref_alu(op, a, b);
        ee  = (op > 4'd8);
        ed  = ee ? 8'h00 : (ovr_en ? ovr_val : r[7:0]);
        ef  = ee ? 1'b0 : (ovr_en ? ovr_flag : ((op <= 4'd3) ? r[8] : 1'b0));
        lat = ee ? 1 : ((op == 4'd2 || op == 4'd3) ? 3 : 2);

        checks++;
        if ({req_ready, rsp_valid, ctl} !== {1'b1, 1'b0, 10'b0}) begin
            errors++;
            $display("FAIL idle_pre op=%0d got rdy=%b vld=%b ctl=%b want rdy=1 vld=0 ctl=0", op, req_ready, rsp_valid, ctl);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);

        for (int k = 1; k < lat; k++) begin
            ec = (lat == 3 && k == 1) ? 10'b0010000000 : opmask(op);
            checks++;
            if ({ctl, alu_in1, alu_in2, rsp_valid, req_ready} !== {ec, a, b, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL alu_cycle op=%0d k=%0d got ctl=%b in1=%h in2=%h vld=%b rdy=%b want ctl=%b in1=%h in2=%h vld=0 rdy=0",
                         op, k, ctl, alu_in1, alu_in2, rsp_valid, req_ready, ec, a, b);
            end
            @(negedge clk);
        end

        for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_flag, rsp_err, req_ready, ctl, alu_in1, alu_in2} !==
                {1'b1, ed, ef, ee, 1'b0, 10'b0, 8'h00, 8'h00}) begin
                errors++;
                $display("FAIL response op=%0d h=%0d got vld=%b data=%h flag=%b err=%b rdy=%b ctl=%b in1=%h in2=%h want vld=1 data=%h flag=%b err=%b rdy=0 ctl=0 in=0",
                         op, h, rsp_valid, rsp_data, rsp_flag, rsp_err, req_ready, ctl, alu_in1, alu_in2, ed, ef, ee);
            end
            if (h == hold) begin
                rsp_ready = 1'b1;
                req_valid = 1'b0;
            end else begin
                req_valid = 1'($urandom);
                req_op    = 4'($urandom);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
`ifdef ALU_ISSUE_OPCOUNT_EN
        if (exp_count < 32'hFFFF) exp_count++;
        checks++;
        if (op_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL op_count got %h want %h", op_count, 16'(exp_count));
        end
`endif
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL post_handshake op=%0d got vld=%b rdy=%b want vld=0 rdy=1", op, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        req_op    = 4'd0;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_flag, rsp_err, ctl, alu_in1, alu_in2} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b data=%h flag=%b err=%b ctl=%b in1=%h in2=%h want rdy=1 rest 0",
                     req_ready, rsp_valid, rsp_data, rsp_flag, rsp_err, ctl, alu_in1, alu_in2);
        end
`ifdef ALU_ISSUE_OPCOUNT_EN
        exp_count = 0;
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_op_count got %h want 0000", op_count);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        do_txn(4'd0, 8'hFF, 8'h02, 0);
    endtask

    task automatic test_lsh();
        ovr_en   = 1'b1;
        ovr_val  = 8'h02;
        ovr_flag = 1'b1;
        do_txn(4'd2, 8'h09, 8'h00, 0);
        ovr_en = 1'b0;
    endtask

    task automatic test_backpressure();
        do_txn(4'd6, 8'h0F, 8'h05, 3);
    endtask

    task automatic test_illegal();
        do_txn(4'hC, 8'h33, 8'h44, 1);
    endtask

    task automatic test_reset_mid_exec();
        req_valid = 1'b1;
        req_op    = 4'd1;
        req_a     = 8'h40;
        req_b     = 8'h10;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (ctl !== 10'b0100000000) begin
            errors++;
            $display("FAIL mid_exec_ctl got %b want 0100000000", ctl);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, ctl, alu_in1, rsp_data} !== {1'b1, 1'b0, 10'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_in_exec got rdy=%b vld=%b ctl=%b in1=%h data=%h want rdy=1 rest 0",
                     req_ready, rsp_valid, ctl, alu_in1, rsp_data);
        end
`ifdef ALU_ISSUE_OPCOUNT_EN
        exp_count = 0;
`endif
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready, ctl} !== {1'b0, 1'b1, 10'b0}) begin
                errors++;
                $display("FAIL dropped_request i=%0d got vld=%b rdy=%b ctl=%b want vld=0 rdy=1 ctl=0", i, rsp_valid, req_ready, ctl);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_txn(4'(i + 3), 8'($urandom), 8'($urandom), 0);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            do_txn(op, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

`ifdef ALU_ISSUE_OPCOUNT_EN
    task automatic test_opcount_saturate();
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        exp_count = 32'hFFFF;
        do_txn(4'd4, 8'hF0, 8'h3C, 0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b0;
        test_reset();
        test_add_overflow();
        test_lsh();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
`ifdef ALU_ISSUE_OPCOUNT_EN
        test_opcount_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_controller.md
ALU_ISSUE_CONTROLLER -- requirements
Module: alu_issue_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand/result width; must match the ALU it drives.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-005 SHALL have ports req_op input 4, req_a input DATA_WIDTH, req_b input DATA_WIDTH: opcode and operands.
REQ-006 SHALL have ports alu_in1, alu_in2  output  DATA_WIDTH: operands driven to the ALU.
REQ-007 SHALL have outputs alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_clr, each 1 bit: ALU controls.
REQ-008 SHALL have inputs alu_out DATA_WIDTH, alu_overflow 1, alu_shift_flag 1: ALU results.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output DATA_WIDTH, rsp_flag output 1, rsp_err output 1: response.

Function
REQ-010 Opcodes SHALL be ADD=0, SUB=1, LSH=2, RSH=3, AND=4, OR=5, XOR=6, INV=7, CLR=8; 9-15 illegal.
REQ-011 FSM states SHALL be IDLE, LOAD, EXEC, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready; op/operands registered on accept.
REQ-013 On accept: shift op -> LOAD; other legal op -> EXEC; illegal op -> RESP.
REQ-014 LOAD SHALL last one cycle, assert alu_lsr only, then go to EXEC.
REQ-015 EXEC SHALL last one cycle, assert exactly one control matching the op, then go to RESP.
REQ-016 At most one alu_* control SHALL be high in any cycle; all low in IDLE and RESP.
REQ-017 alu_in1/alu_in2 SHALL drive registered operands in LOAD and EXEC, zero otherwise.
REQ-018 alu_out SHALL be captured into rsp_data at the end of EXEC.
REQ-019 rsp_flag SHALL capture alu_overflow for ADD/SUB, alu_shift_flag for LSH/RSH, 0 otherwise.
REQ-020 Illegal op SHALL give rsp_data=0, rsp_flag=0, rsp_err=1 with no ALU control asserted; legal ops give rsp_err=0.
REQ-021 rsp_valid SHALL be 1 exactly in RESP; rsp_data/flag/err stable while rsp_valid & ~rsp_ready.
REQ-022 RESP -> IDLE on rsp_ready; next accept no earlier than the following cycle.
REQ-023 Latency accept(cycle N) to rsp_valid: N+2 non-shift, N+3 shift, N+1 illegal.

Reset
REQ-024 reset SHALL take effect in any state at the next clock edge: state IDLE, pending request dropped.
REQ-025 After reset all outputs SHALL be 0 except req_ready=1.

Configuration
REQ-026 Macro ALU_ISSUE_OPCOUNT_EN defined: SHALL add output op_count [15:0], +1 per response handshake, saturating at 0xFFFF, reset to 0.
REQ-027 Macro absent: op_count port and counter SHALL not exist; other behaviour identical.

Structure
REQ-028 Package alu_issue_pkg SHALL hold opcode constants, OP_WIDTH=4, FSM state encoding.
REQ-029 Sub-module alu_op_decode (combinational): opcode -> one-hot control vector, is_shift, illegal.

Verification
REQ-030 ADD a=0xFF b=0x02, ALU model returns 0x01/ovf=1 -> rsp_data=0x01, rsp_flag=1, rsp_valid at N+2, alu_add high only at N+1.
REQ-031 LSH a=0x09, model returns 0x02/shift_flag=1 -> alu_lsr only at N+1, alu_lsh only at N+2, rsp_data=0x02, rsp_flag=1 at N+3.
REQ-032 XOR a=0x0F b=0x05, rsp_ready low 3 cycles -> rsp_valid and rsp_data=0x0A held, req_ready=0 throughout.
REQ-033 req_op=0xC -> rsp_err=1, rsp_data=0 at N+1, no alu_* control ever high.
REQ-034 reset asserted during EXEC of SUB -> next cycle IDLE, rsp_valid=0, req_ready=1, no response issued.
REQ-035 With ALU_ISSUE_OPCOUNT_EN: 3 completed handshakes -> op_count=3; preload 0xFFFF + 1 handshake -> stays 0xFFFF.
